// File: rtl/accel_pkg.sv
// accel_pkg: shared memory protocol types, sizes and bank remap helper
package accel_pkg;
  localparam int BRAM_BANKS = 19;
  localparam int BRAM_DEPTH = 2048;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int BANK_W = 5;
  localparam int RESP_LATENCY = 2;
  localparam int ERR_BAD_BANK = 0;
  localparam int ERR_BAD_ADDR = 1;
  localparam int ERR_RW_BOTH = 2;
  localparam int ERR_CONFLICT = 3;
  typedef enum logic {PORT_ACCEL, PORT_HOST} mem_port_e;
  typedef struct packed {
    logic re;
    logic we;
    logic [BANK_W-1:0] bank_sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
  typedef struct packed {
    logic ready;
    logic valid;
    logic [DATA_W-1:0] data;
  } mem_resp_t;
  function automatic logic [BANK_W-1:0] remap(input logic [BANK_W-1:0] b, input logic si, input logic so);
    return ((si && b[BANK_W-1:1] == '0) || (so && b[BANK_W-1:1] == (BANK_W-1)'(1))) ? {b[BANK_W-1:1], ~b[0]} : b;
  endfunction
endpackage

// File: rtl/bram_bank_responder_bank.sv
// bram_bank: single-port synchronous RAM, registered write-first read
module bram_bank
  import accel_pkg::*;
#(
  parameter int DEPTH = BRAM_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // access port: write commits now, read word (or written word) is registered
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= we ? wdata : mem[addr];
    end
  end
endmodule

// File: rtl/bram_bank_responder.sv
// bram_bank_responder: two-port round-robin responder over remappable BRAM banks
module bram_bank_responder
  import accel_pkg::*;
#(
  parameter int N_BANKS = BRAM_BANKS,
  parameter int DEPTH = BRAM_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  mem_req_t  req_i [2],
  output mem_resp_t resp_o [2],
  input  logic      swap_in_i,
  input  logic      swap_out_i,
  input  logic      err_clr_i,
  output logic [7:0] err_flags_o
);
  localparam int AW = $clog2(DEPTH);
  logic sw_in, sw_out, conflict;
  mem_port_e rr;
  logic [1:0] pres, bad_bank, bad_addr, bad_rw, legal, gnt, acc, s1_v, s2_v;
  logic [BANK_W-1:0] phys [2];
  logic [BANK_W-1:0] s1_b [2];
  logic [DATA_W-1:0] s2_d [2];
  logic [DATA_W-1:0] rdata [N_BANKS];
  logic [7:0] err_set;
  assign conflict = legal[0] & legal[1] & (phys[0] == phys[1]);
  for (genvar p = 0; p < 2; p++) begin : g_port
    assign pres[p] = req_i[p].re | req_i[p].we;
    assign bad_bank[p] = pres[p] & (32'(req_i[p].bank_sel) >= N_BANKS);
    assign bad_addr[p] = pres[p] & (|req_i[p].addr[ADDR_W-1:AW]);
    assign bad_rw[p] = req_i[p].re & req_i[p].we;
    assign legal[p] = pres[p] & ~(bad_bank[p] | bad_addr[p] | bad_rw[p]);
    assign phys[p] = remap(req_i[p].bank_sel, sw_in, sw_out);
    assign gnt[p] = rst_n & pres[p] & (~legal[p] | ~conflict | (rr == mem_port_e'(p)));
    assign acc[p] = gnt[p] & legal[p];
    assign resp_o[p] = '{ready: gnt[p], valid: s2_v[p], data: s2_d[p]};
  end
  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic h0, h1;
    assign h0 = acc[0] & (phys[0] == BANK_W'(b));
    assign h1 = acc[1] & (phys[1] == BANK_W'(b));
    bram_bank #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_bank (
      .clk  (clk),
      .en   (h0 | h1),
      .we   (req_i[h1].we),
      .addr (req_i[h1].addr[AW-1:0]),
      .wdata(req_i[h1].wdata),
      .rdata(rdata[b])
    );
  end
  // error bits raised by this cycle's requests
  always_comb begin
    err_set = '0;
    err_set[ERR_BAD_BANK] = |bad_bank;
    err_set[ERR_BAD_ADDR] = |bad_addr;
    err_set[ERR_RW_BOTH] = |bad_rw;
    err_set[ERR_CONFLICT] = conflict;
  end
  // swap maps, round-robin pointer and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_in <= 1'b0;
      sw_out <= 1'b0;
      rr <= PORT_ACCEL;
      err_flags_o <= '0;
    end else begin
      sw_in <= sw_in ^ swap_in_i;
      sw_out <= sw_out ^ swap_out_i;
      rr <= conflict ? (rr == PORT_ACCEL ? PORT_HOST : PORT_ACCEL) : rr;
      err_flags_o <= (err_clr_i ? 8'h00 : err_flags_o) | err_set;
    end
  end
  // read tag pipe: accept -> bank tag -> registered return word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= '0;
      s2_v <= '0;
      s1_b <= '{default: '0};
      s2_d <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        s1_v[i] <= acc[i] & req_i[i].re;
        s1_b[i] <= phys[i];
        s2_v[i] <= s1_v[i];
        s2_d[i] <= s1_v[i] ? rdata[s1_b[i]] : '0;
      end
    end
  end
endmodule
